// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller in front of the CPU irq pin.
// Each raw source passes through a two-flop synchronizer and a rising-edge
// detector. Detected edges latch into PENDING, PENDING is masked by ENABLE,
// and the result drives a registered irq. CAUSE reports the lowest-index
// enabled pending source.
// Optional feature: define IRQ_TIMER_EN to add a 24-bit periodic timer that
// feeds pending bit NUM_SRC directly, without a synchronizer.
// Register map (addr = data_addr[3:2]):
//   0 PENDING (W1C, byte 0), 1 ENABLE (RW, byte 0), 2 CAUSE (RO),
//   3 TIMER (RW [23:0], accepted only when bytes 0..2 are all written).
// This block has no valid/ready handshake: each enabled write is a
// single-cycle bus strobe, and reads are combinational with no side effects.
module irq_controller #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wenable,
    output logic [31:0]        rdata,
    output logic               irq
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_CAUSE   = 2'd2;
    localparam logic [1:0] ADDR_TIMER   = 2'd3;

    // Synchronizer chain (s1 -> s2) and previous-value flop s3.
    logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
    logic [NUM_SRC-1:0] src_edge;

    logic [7:0] pending_q, pending_d;
    logic [7:0] enable_q, enable_d;
    logic       irq_q, irq_d;

    logic [7:0] set_v;
    logic [7:0] clear_v;
    logic [7:0] valid_mask;
    logic [7:0] hit;
    logic [2:0] cause_idx;
    logic [23:0] timer_rd;
    logic       timer_evt;

    assign src_edge = s2_q & ~s3_q;

`ifdef IRQ_TIMER_EN
    logic [23:0] reload_q, reload_d;
    logic [23:0] count_q, count_d;
    logic        timer_wr;
    logic        unused_bits;

    assign timer_wr    = (addr == ADDR_TIMER) && (&wenable[2:0]);
    assign unused_bits = ^{wdata[31:24], wenable[3]};

    // Timer: load on a full TIMER write, otherwise count down and reload at zero.
    always_comb begin
        reload_d  = reload_q;
        count_d   = count_q;
        timer_evt = 1'b0;
        if (timer_wr) begin
            reload_d = wdata[23:0];
            count_d  = wdata[23:0];
        end else if (reload_q != 24'd0) begin
            if (count_q == 24'd0) begin
                count_d   = reload_q;
                timer_evt = 1'b1;
            end else begin
                count_d = count_q - 24'd1;
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= 24'd0;
            count_q  <= 24'd0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
        end
    end

    assign timer_rd = count_q;
`else
    logic unused_bits;

    assign unused_bits = ^{wdata[31:8], wenable[3:1]};
    assign timer_evt   = 1'b0;
    assign timer_rd    = 24'd0;
`endif

    // Next-state for PENDING, ENABLE and irq; a set beats a same-cycle W1C.
    always_comb begin
        set_v      = 8'd0;
        valid_mask = 8'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            set_v[i]      = src_edge[i];
            valid_mask[i] = 1'b1;
        end
`ifdef IRQ_TIMER_EN
        set_v[NUM_SRC]      = timer_evt;
        valid_mask[NUM_SRC] = 1'b1;
`endif
        clear_v = 8'd0;
        if ((addr == ADDR_PENDING) && wenable[0]) begin
            clear_v = wdata[7:0];
        end
        pending_d = ((pending_q & ~clear_v) | set_v) & valid_mask;
        enable_d  = enable_q;
        if ((addr == ADDR_ENABLE) && wenable[0]) begin
            enable_d = wdata[7:0];
        end
        irq_d = |(pending_d & enable_d);
    end

    // Synchronizers, edge history, PENDING, ENABLE and the irq register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pending_q <= 8'd0;
            enable_q  <= 8'd0;
            irq_q     <= 1'b0;
        end else begin
            s1_q      <= src;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

    // Cause: lowest-index enabled pending source (scan high to low, last hit wins).
    always_comb begin
        hit       = pending_q & enable_q;
        cause_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (hit[i]) begin
                cause_idx = i[2:0];
            end
        end
    end

    // Read mux: pure function of addr and current register state.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_PENDING: rdata = {24'd0, pending_q};
            ADDR_ENABLE:  rdata = {24'd0, enable_q};
            ADDR_CAUSE:   rdata = {|hit, 28'd0, cause_idx};
            ADDR_TIMER:   rdata = {8'd0, timer_rd};
            default:      rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller: edge capture, masking, priority,
// W1C, set/clear collision, asynchronous reset and (if built in) the timer.
// Inputs are driven and outputs sampled around the falling edge.
module tb_irq_controller;

    localparam int NUM_SRC = 4;

    logic               clk;
    logic               rst;
    logic [NUM_SRC-1:0] src;
    logic [1:0]         addr;
    logic [31:0]        wdata;
    logic [3:0]         wenable;
    logic [31:0]        rdata;
    logic               irq;

    int n_checks;
    int n_errors;
    logic [31:0] exp_q[$];

    irq_controller #(.NUM_SRC(NUM_SRC)) dut (
        .clk     (clk),
        .rst     (rst),
        .src     (src),
        .addr    (addr),
        .wdata   (wdata),
        .wenable (wenable),
        .rdata   (rdata),
        .irq     (irq)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Driver: one-cycle register write, called just after a falling edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        addr    = a;
        wdata   = d;
        wenable = be;
        @(negedge clk);
        wenable = 4'b0000;
    endtask

    // Scoreboard read: expected value goes through exp_q, then is compared.
    task automatic expect_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        addr = a;
        #1;
        check(tag, rdata, exp_q.pop_front());
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        src      = '0;
        addr     = 2'd0;
        wdata    = 32'd0;
        wenable  = 4'b0000;

        // Reset state, sampled while rst is still asserted.
        @(negedge clk);
        #1;
        check("reset_irq", {31'd0, irq}, 32'd0);
        expect_read("reset_pending", 2'd0, 32'd0);
        expect_read("reset_enable",  2'd1, 32'd0);
        expect_read("reset_cause",   2'd2, 32'd0);
        expect_read("reset_timer",   2'd3, 32'd0);
        wait (rst == 1'b0);
        @(negedge clk);

        // Edge capture: irq rises after exactly three rising edges.
        bus_write(2'd1, 32'h0000_0001, 4'b0001);
        expect_read("enable_rw", 2'd1, 32'h01);
        src[0] = 1'b1;
        step(2);
        check("edge_irq_e2", {31'd0, irq}, 32'd0);
        expect_read("edge_pending_e2", 2'd0, 32'h00);
        step(1);
        check("edge_irq_e3", {31'd0, irq}, 32'd1);
        expect_read("edge_pending_e3", 2'd0, 32'h01);
        expect_read("edge_cause", 2'd2, 32'h8000_0000);
        // Writes to CAUSE do nothing.
        bus_write(2'd2, 32'h0000_0007, 4'b1111);
        expect_read("cause_ro", 2'd2, 32'h8000_0000);
        // W1C of the last enabled pending bit drops irq on the write edge.
        bus_write(2'd0, 32'h0000_0001, 4'b0001);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        expect_read("w1c_pending", 2'd0, 32'h00);
        src[0] = 1'b0;
        step(4);

        // Masked source still latches; unmasking raises irq on the write edge.
        bus_write(2'd1, 32'h0000_0000, 4'b0001);
        src[2] = 1'b1;
        step(4);
        expect_read("masked_pending", 2'd0, 32'h04);
        check("masked_irq", {31'd0, irq}, 32'd0);
        bus_write(2'd1, 32'h0000_0004, 4'b0001);
        check("unmask_irq", {31'd0, irq}, 32'd1);
        expect_read("unmask_cause", 2'd2, 32'h8000_0002);
        bus_write(2'd0, 32'h0000_0004, 4'b0001);
        src[2] = 1'b0;
        step(4);

        // Priority and W1C.
        bus_write(2'd1, 32'h0000_000A, 4'b0001);
        src[1] = 1'b1;
        src[3] = 1'b1;
        step(4);
        expect_read("prio_pending", 2'd0, 32'h0A);
        expect_read("prio_cause_1", 2'd2, 32'h8000_0001);
        bus_write(2'd0, 32'h0000_0002, 4'b0001);
        expect_read("prio_cause_3", 2'd2, 32'h8000_0003);
        check("prio_irq_held", {31'd0, irq}, 32'd1);
        bus_write(2'd0, 32'h0000_0008, 4'b0001);
        check("prio_irq_low", {31'd0, irq}, 32'd0);
        expect_read("prio_cause_0", 2'd2, 32'h0000_0000);
        src[1] = 1'b0;
        src[3] = 1'b0;
        step(4);

        // Set/clear collision: W1C lands on the same edge that sets bit 0.
        src[0] = 1'b1;
        step(2);
        bus_write(2'd0, 32'h0000_0001, 4'b0001);
        expect_read("collide_pending", 2'd0, 32'h01);
        check("collide_irq_masked", {31'd0, irq}, 32'd0);

        // Timer register: full write loads, partial write is ignored.
        bus_write(2'd3, 32'h0012_3456, 4'b0111);
`ifdef IRQ_TIMER_EN
        expect_read("timer_load", 2'd3, 32'h0012_3456);
`else
        expect_read("timer_absent", 2'd3, 32'h0000_0000);
`endif
        bus_write(2'd3, 32'h00AB_CDEF, 4'b0011);
`ifdef IRQ_TIMER_EN
        expect_read("timer_partial", 2'd3, 32'h0012_3455);
`else
        expect_read("timer_partial", 2'd3, 32'h0000_0000);
`endif

        // Reset mid-operation clears everything without waiting for a clock.
        bus_write(2'd1, 32'h0000_0001, 4'b0001);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        expect_read("rst_pending", 2'd0, 32'd0);
        expect_read("rst_enable",  2'd1, 32'd0);
        expect_read("rst_timer",   2'd3, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // src[0] held high through reset counts as one fresh edge.
        step(2);
        expect_read("held_e2", 2'd0, 32'h00);
        step(1);
        expect_read("held_e3", 2'd0, 32'h01);
        bus_write(2'd0, 32'h0000_0001, 4'b0001);
        src[0] = 1'b0;
        step(2);
        // A steady high level does not re-trigger.
        expect_read("no_retrigger", 2'd0, 32'h00);

`ifdef IRQ_TIMER_EN
        // Timer: reload 4 gives one event every 5 cycles.
        bus_write(2'd1, 32'h0000_0001 << NUM_SRC, 4'b0001);
        bus_write(2'd3, 32'h0000_0004, 4'b0111);
        expect_read("tmr_start", 2'd3, 32'h04);
        step(3);
        expect_read("tmr_quiet", 2'd0, 32'h00);
        check("tmr_quiet_irq", {31'd0, irq}, 32'd0);
        step(1);
        expect_read("tmr_zero", 2'd3, 32'h00);
        step(1);
        expect_read("tmr_evt1", 2'd0, 32'h01 << NUM_SRC);
        check("tmr_evt1_irq", {31'd0, irq}, 32'd1);
        expect_read("tmr_reload", 2'd3, 32'h04);
        bus_write(2'd0, 32'h0000_0001 << NUM_SRC, 4'b0001);
        expect_read("tmr_live", 2'd3, 32'h03);
        step(3);
        expect_read("tmr_gap", 2'd0, 32'h00);
        step(1);
        expect_read("tmr_evt2", 2'd0, 32'h01 << NUM_SRC);
        bus_write(2'd0, 32'h0000_0001 << NUM_SRC, 4'b0001);
        bus_write(2'd3, 32'h0000_0000, 4'b0111);
        step(12);
        expect_read("tmr_stopped", 2'd0, 32'h00);
        expect_read("tmr_held0", 2'd3, 32'h00);
        check("tmr_stopped_irq", {31'd0, irq}, 32'd0);
`else
        // Without the timer, pending bit NUM_SRC stays zero.
        bus_write(2'd1, 32'h0000_00FF, 4'b0001);
        bus_write(2'd3, 32'h0000_0001, 4'b0111);
        step(6);
        expect_read("no_tmr_pending", 2'd0, 32'h00);
        check("no_tmr_irq", {31'd0, irq}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
